imm_gen_pipe: RTL and testbench



---
 rtl/imm_pkg.sv | 23 ++
 rtl/imm_extract.sv | 70 +++++++
 rtl/imm_gen_pipe.sv | 96 +++++++++
 tb/tb_imm_gen_pipe.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared format codes and RV64I opcode constants for the immediate generator.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_NONE = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate decode: format code, sign-extended immediate and
// the byte offset used for PC-relative targets.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int BRANCH_HALF = 0
) (
  input  logic [31:0]     instr,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] off,
  output logic            pc_rel
);

  logic [11:0] i_imm;
  logic [11:0] s_imm;
  logic [12:0] b_off;
  logic [31:0] u_imm;
  logic [20:0] j_off;

  assign i_imm = instr[31:20];
  assign s_imm = {instr[31:25], instr[11:7]};
  assign b_off = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u_imm = {instr[31:12], 12'b0};
  assign j_off = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    fmt    = FMT_NONE;
    imm    = '0;
    off    = '0;
    pc_rel = 1'b0;
    case (instr[6:0])
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR: begin
        fmt = FMT_I;
        imm = XLEN'($signed(i_imm));
      end
      OP_STORE: begin
        fmt = FMT_S;
        imm = XLEN'($signed(s_imm));
      end
      OP_BRANCH: begin
        fmt    = FMT_B;
        off    = XLEN'($signed(b_off));
        pc_rel = 1'b1;
        // The target always uses the byte offset; only the reported immediate changes.
        if (BRANCH_HALF != 0) imm = XLEN'($signed(b_off[12:1]));
        else                  imm = XLEN'($signed(b_off));
      end
      OP_LUI: begin
        fmt = FMT_U;
        imm = XLEN'($signed(u_imm));
      end
      OP_AUIPC: begin
        fmt    = FMT_U;
        imm    = XLEN'($signed(u_imm));
        off    = XLEN'($signed(u_imm));
        pc_rel = 1'b1;
      end
      OP_JAL: begin
        fmt    = FMT_J;
        imm    = XLEN'($signed(j_off));
        off    = XLEN'($signed(j_off));
        pc_rel = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage immediate generator: S1 decodes and captures the PC, S2 adds the
// PC-relative target and holds the result under valid/ready flow control.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int BRANCH_HALF = 0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [XLEN-1:0]  out_target,
  output logic [CNT_W-1:0] err_cnt
);

  logic [2:0]      ex_fmt;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_off;
  logic            ex_pc_rel;

  logic            s1_valid;
  logic [2:0]      s1_fmt;
  logic [XLEN-1:0] s1_imm;
  logic [XLEN-1:0] s1_off;
  logic [XLEN-1:0] s1_pc;
  logic            s1_pc_rel;
  logic            s2_loads;

  imm_extract #(
    .XLEN        (XLEN),
    .BRANCH_HALF (BRANCH_HALF)
  ) u_extract (
    .instr  (in_instr),
    .fmt    (ex_fmt),
    .imm    (ex_imm),
    .off    (ex_off),
    .pc_rel (ex_pc_rel)
  );

  assign s2_loads = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_loads;

  // When in_ready is high S1 is either empty or moving into S2 this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_fmt    <= '0;
      s1_imm    <= '0;
      s1_off    <= '0;
      s1_pc     <= '0;
      s1_pc_rel <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_fmt    <= ex_fmt;
        s1_imm    <= ex_imm;
        s1_off    <= ex_off;
        s1_pc     <= in_pc;
        s1_pc_rel <= ex_pc_rel;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_fmt    <= '0;
      out_imm    <= '0;
      out_target <= '0;
    end else if (s2_loads) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_fmt    <= s1_fmt;
        out_imm    <= s1_imm;
        out_target <= s1_pc_rel ? s1_pc + s1_off : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && out_fmt == FMT_NONE && err_cnt != '1) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode vectors, latency, backpressure,
// error-counter saturation and asynchronous reset.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready, in_ready_h;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        out_ready;
  logic        out_valid, out_valid_h;
  logic [63:0] out_imm, out_imm_h;
  logic [2:0]  out_fmt, out_fmt_h;
  logic [63:0] out_target, out_target_h;
  logic [1:0]  err_cnt;
  logic [15:0] err_cnt_h;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .BRANCH_HALF(0), .CNT_W(2)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_target(out_target), .err_cnt(err_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .BRANCH_HALF(1), .CNT_W(16)) u_dut_h (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_h),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_h), .out_ready(out_ready),
    .out_imm(out_imm_h), .out_fmt(out_fmt_h), .out_target(out_target_h), .err_cnt(err_cnt_h)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One instruction through an idle pipe with out_ready high.
  task automatic run_one(input string tag, input logic [31:0] instr, input logic [63:0] pc,
                         input logic [2:0] fmt, input logic [63:0] imm,
                         input logic [63:0] imm_h, input logic [63:0] tgt);
    @(negedge clk);
    in_valid = 1'b1; in_instr = instr; in_pc = pc; out_ready = 1'b1;
    #1 check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check({tag, " early"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    #1;
    check({tag, " valid"}, 64'(out_valid), 64'd1);
    check({tag, " fmt"}, 64'(out_fmt), 64'(fmt));
    check({tag, " imm"}, out_imm, imm);
    check({tag, " target"}, out_target, tgt);
    check({tag, " imm_h"}, out_imm_h, imm_h);
    check({tag, " target_h"}, out_target_h, tgt);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    #1;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_imm", out_imm, 64'd0);
    check("rst out_fmt", 64'(out_fmt), 64'd0);
    check("rst out_target", out_target, 64'd0);
    check("rst err_cnt", 64'(err_cnt), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    run_one("ld",    32'hFF813083, 64'h2000, 3'd0, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0);
    run_one("beq",   32'hFE000EE3, 64'h1000, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFC);
    run_one("lui",   32'h800002B7, 64'h3000, 3'd3, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 64'h0);
    run_one("jal",   32'h001000EF, 64'h0,    3'd4, 64'h800, 64'h800, 64'h800);
    run_one("auipc", 32'h00001297, 64'h100,  3'd3, 64'h1000, 64'h1000, 64'h1100);
    run_one("sd",    32'hFE113823, 64'h500,  3'd1, 64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0);
    run_one("jalr",  32'h00C080E7, 64'h4000, 3'd0, 64'hC, 64'hC, 64'h0);
    check("err idle", 64'(err_cnt), 64'd0);

    // Backpressure: three addi with immediates 1, 2, 3.
    for (int unsigned t = 0; t < 9; t++) begin
      @(negedge clk);
      case (t)
        0: begin out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093; end
        1: in_instr = 32'h00200093;
        2: in_instr = 32'h00300093;
        5: out_ready = 1'b1;
        6: in_valid = 1'b0;
        default: ;
      endcase
      #1;
      if (t <= 1) check($sformatf("bp in_ready t%0d", t), 64'(in_ready), 64'd1);
      if (t >= 2 && t <= 4) begin
        check($sformatf("bp in_ready t%0d", t), 64'(in_ready), 64'd0);
        check($sformatf("bp hold imm t%0d", t), out_imm, 64'd1);
        check($sformatf("bp hold valid t%0d", t), 64'(out_valid), 64'd1);
      end
      if (t == 5) check("bp release in_ready", 64'(in_ready), 64'd1);
      if (t >= 5 && t <= 7) begin
        check($sformatf("bp order valid t%0d", t), 64'(out_valid), 64'd1);
        check($sformatf("bp order imm t%0d", t), out_imm, 64'(t - 4));
      end
      if (t == 8) check("bp drained", 64'(out_valid), 64'd0);
    end

    // Unknown opcodes streamed back to back; 2-bit counter saturates at 3.
    for (int unsigned t = 0; t < 7; t++) begin
      @(negedge clk);
      if (t == 0) begin in_valid = 1'b1; in_instr = 32'h0; out_ready = 1'b1; end
      if (t == 4) in_valid = 1'b0;
      #1;
      if (t >= 2 && t <= 5) begin
        check($sformatf("none fmt t%0d", t), 64'(out_fmt), 64'd7);
        check($sformatf("none imm t%0d", t), out_imm, 64'd0);
        check($sformatf("none target t%0d", t), out_target, 64'd0);
      end
      if (t >= 3) check($sformatf("err_cnt t%0d", t), 64'(err_cnt), 64'((t - 2 > 3) ? 3 : t - 2));
    end
    check("err_cnt_h", 64'(err_cnt_h), 64'd4);

    // Two NONE results stalled, then asynchronous reset mid-cycle.
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre-rst valid", 64'(out_valid), 64'd1);
    check("pre-rst in_ready", 64'(in_ready), 64'd0);
    check("pre-rst err", 64'(err_cnt), 64'd3);
    #1 reset = 1'b0;
    #1;
    check("async out_valid", 64'(out_valid), 64'd0);
    check("async err_cnt", 64'(err_cnt), 64'd0);
    check("async err_cnt_h", 64'(err_cnt_h), 64'd0);
    check("async in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1; reset = 1'b1;
    for (int unsigned t = 0; t < 3; t++) begin
      @(negedge clk);
      #1;
      check($sformatf("post-rst valid t%0d", t), 64'(out_valid), 64'd0);
      check($sformatf("post-rst err t%0d", t), 64'(err_cnt), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
